// File: rtl/adma_desc_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : adma_desc_responder
// Description : ADMA descriptor-table responder with a fixed-latency
//               valid/ready fetch port and an error response for illegal
//               addresses. Optional macro ADMA_DESC_STATS_EN adds
//               fetch/error counters.
// Revision    : 1.0 - initial release
// ============================================================================
module adma_desc_responder #(
  parameter int          DEPTH     = 16,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0000_1000,
  parameter int          LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_valid,
  input  logic [$clog2(DEPTH)-1:0] ld_index,
  input  logic [95:0]              ld_data,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [63:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [95:0]              resp_data,
  output logic                     resp_error
`ifdef ADMA_DESC_STATS_EN
  ,
  output logic [15:0]              fetch_count,
  output logic [15:0]              err_count
`endif
);

  localparam int          c_IW      = $clog2(DEPTH);
  localparam logic [60:0] c_DEPTH_W = 61'(DEPTH);
  localparam logic [3:0]  c_LAT_M1  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [95:0]       r_table [DEPTH];
  logic [c_IW-1:0]   r_idx;
  logic              r_err;
  logic [3:0]        r_wait;
  logic [95:0]       r_resp_data;
  logic              r_resp_error;

  logic [63:0]       w_off;
  logic              w_illegal;
  logic              w_accept;
  logic              w_capture;
  logic              w_handshake;

  // Offset-relative misalignment is also checked so an unaligned base can
  // never map a request onto a partial entry.
  assign w_off       = req_addr - BASE_ADDR;
  assign w_illegal   = (req_addr < BASE_ADDR) || (req_addr[2:0] != 3'b000) ||
                       (w_off[2:0] != 3'b000) || (w_off[63:3] >= c_DEPTH_W);
  assign w_accept    = req_valid && (r_state == ST_IDLE);
  assign w_capture   = (r_state == ST_WAIT) && (r_wait == 4'd0);
  assign w_handshake = (r_state == ST_RESP) && resp_ready;

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = (r_state == ST_RESP);
  assign resp_data   = r_resp_data;
  assign resp_error  = r_resp_error;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)    w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_capture)   w_state_nxt = ST_RESP;
      ST_RESP: if (w_handshake) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_err        <= 1'b0;
      r_wait       <= 4'd0;
      r_resp_data  <= '0;
      r_resp_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx  <= w_off[c_IW+2:3];
        r_err  <= w_illegal;
        r_wait <= c_LAT_M1;
      end else if (r_state == ST_WAIT && r_wait != 4'd0) begin
        r_wait <= r_wait - 4'd1;
      end
      // Table read sees the pre-edge contents, so a same-cycle load returns old data.
      if (w_capture) begin
        r_resp_data  <= r_err ? '0 : r_table[r_idx];
        r_resp_error <= r_err;
      end
    end
  end

  // Table storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (ld_valid) r_table[ld_index] <= ld_data;
  end

`ifdef ADMA_DESC_STATS_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else if (w_handshake) begin
      if (r_fetch_cnt != 16'hFFFF)                 r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (r_resp_error && r_err_cnt != 16'hFFFF)   r_err_cnt   <= r_err_cnt + 16'd1;
    end
  end

  assign fetch_count = r_fetch_cnt;
  assign err_count   = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/adma_desc_responder.md
# adma_desc_responder

Descriptor-table responder that serves the ADMA engine's descriptor fetches. It holds a DEPTH-entry table of 96-bit ADMA descriptor lines in local storage. Software or the testbench loads entries through a load port. The engine reads entries back through a valid/ready fetch port with a fixed, programmable latency and an error response. It sits between the ADMA engine's ST_FDS fetch and system memory and replaces the combinational table lookup.

## Interface
Parameters:
- `DEPTH`, 16: number of descriptor entries. Must be a power of two, 2..256.
- `BASE_ADDR`, 64'h0000_0000_0000_1000: system address of entry 0.
- `LATENCY`, 2: cycles from request acceptance to `resp_valid`. Legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ld_valid`  in  1  write the table entry this cycle.
- `ld_index`  in  $clog2(DEPTH)  entry to write.
- `ld_data`  in  96  descriptor line. Bit fields:
  - [0] Valid, [1] End, [2] Int.
  - [5:4] Act.
  - [31:16] length.
  - [95:32] address.
- `req_valid`  in  1  fetch request.
- `req_ready`  out  1  responder can accept a request.
- `req_addr`  in  64  system address of the descriptor.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  engine consumes the response.
- `resp_data`  out  96  descriptor line.
- `resp_error`  out  1  the address was illegal.
- `fetch_count`  out  16  only with ADMA_DESC_STATS_EN.
- `err_count`  out  16  only with ADMA_DESC_STATS_EN.

## Operation
- Entry stride is 8 bytes, matching the engine's SYS_ADR+8 step. Index = (req_addr − BASE_ADDR) >> 3.
- A request is illegal if any of these holds:
  - req_addr < BASE_ADDR;
  - req_addr[2:0] ≠ 0;
  - index ≥ DEPTH.
- An illegal request returns `resp_error`=1 and `resp_data`=0. Valid=0 causes the engine to raise ADMA_Error.
- State machine:
  - IDLE: `req_ready`=1. On req_valid&&req_ready, latch the index and the error flag, load the wait counter, go to WAIT.
  - WAIT: count down. When LATENCY cycles from acceptance have elapsed, capture the table entry (or zeros on error) into the response register and go to RESP.
  - RESP: `resp_valid`=1, with data and error held stable. On resp_valid&&resp_ready go to IDLE.
- `req_ready`=0 in WAIT and RESP. One outstanding request only; there is no pipelining.
- Load port:
  - Writes take effect at the clock edge and are accepted in any state.
  - If a load hits the entry being captured in the same cycle, the response carries the pre-write (old) data.
  - Table contents are not reset.
- The responder does not interpret descriptor fields. Data returns bit-exact.

## Timing
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_error`=0, state IDLE, counters 0.
- The accepting edge is T. `resp_valid` rises after edge T+LATENCY.
- Minimum turnaround, request to next request accepted, is LATENCY+2 cycles when `resp_ready` is held high.
- `resp_valid` stays high with stable data and error until the handshake, for any number of stall cycles.
- Asserting `rst_n` low mid-operation has these effects:
  - Immediately, without waiting for a clock edge: return to IDLE and drop `resp_valid`. A pending response is discarded.
  - Table contents are preserved.
- `req_addr` is sampled only at the accepting edge. Later changes do not affect the response.

## Configuration
- `ADMA_DESC_STATS_EN` defined:
  - `fetch_count` increments on every response handshake, legal or illegal.
  - `err_count` increments on each handshake with `resp_error`=1.
  - Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- `ADMA_DESC_STATS_EN` undefined: the two ports and their counters are absent. All other behaviour is identical.

## Test plan
- Basic fetch:
  - Stimulus: load index 0 with 96'h0000_0000_0000_2000_0200_0021, request 64'h1000 with `resp_ready`=1, LATENCY=2.
  - Required: `resp_valid` after edge T+2; data equals the loaded value; `resp_error`=0; `req_ready` back to 1 the cycle after the handshake.
- Illegal addresses:
  - Stimulus: requests to 64'h1004 (misaligned), 64'h0FF8 (below base) and 64'h1080 (index 16 with DEPTH=16).
  - Required: each returns `resp_error`=1 and `resp_data`=0. With stats enabled, `err_count`=3 and `fetch_count`=3.
- Backpressure:
  - Stimulus: hold `resp_ready`=0 for 5 cycles after `resp_valid`. Drive a second req_valid during the stall.
  - Required: data stable for all 5 cycles; `req_ready`=0; the second request is not accepted until after the handshake.
- Load collision:
  - Stimulus: index 3 holds A; request 64'h1018; write B to index 3 on the capture cycle.
  - Required: the response is A. The next fetch of 64'h1018 returns B.
- Reset mid-operation:
  - Stimulus: drop `rst_n` during WAIT, then release it.
  - Required: `resp_valid`=0 asynchronously and `req_ready`=1. A fetch after release returns the pre-reset table contents.
- Link walk:
  - Stimulus: load a 4-entry chain (TRAN, TRAN, LINK→64'h1030, TRAN+End at index 6); fetch in sequence 64'h1000, 1008, 1010, 1030.
  - Required: all four lines are returned bit-exact in order, each with `resp_error`=0.
